// File: rtl/tf_mem_paged_bram_pkg.sv
// Shared widths and address helpers for the paged trigger-finder memories.
package tf_mem_paged_bram_pkg;

    localparam int VMPROJ_WIDTH   = 21;
    localparam int AP_WIDTH       = 60;
    localparam int TPROJ_WIDTH    = 60;
    localparam int NENT_WIDTH_DEF = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic logic [31:0] page_of(input logic [31:0] addr, input int depth);
        return addr >> clog2(depth);
    endfunction

endpackage

// File: rtl/tf_mem_paged_bram_if.sv
// Write/read/status bundle between a writer module, the memory and its reader.
interface tf_mem_paged_bram_if
    import tf_mem_paged_bram_pkg::*;
#(
    parameter int RAM_WIDTH  = VMPROJ_WIDTH,
    parameter int NUM_PAGES  = 2,
    parameter int NENT_WIDTH = NENT_WIDTH_DEF,
    parameter int ADDR_WIDTH = 8
);
    logic                            ena;
    logic                            wea;
    logic [ADDR_WIDTH-1:0]           writeaddr;
    logic [RAM_WIDTH-1:0]            din;
    logic [NUM_PAGES-1:0]            nent_we;
    logic [NUM_PAGES*NENT_WIDTH-1:0] nent_din;
    logic [NUM_PAGES-1:0]            page_clr;
    logic                            enb;
    logic [ADDR_WIDTH-1:0]           readaddr;
    logic [RAM_WIDTH-1:0]            dout;
    logic                            dout_vld;
    logic [NUM_PAGES*NENT_WIDTH-1:0] nentries_dout;
    logic [NUM_PAGES-1:0]            err_mismatch;
    logic                            err_addr;

    modport master (
        output ena, wea, writeaddr, din, nent_we, nent_din, page_clr,
        output enb, readaddr,
        input  dout, dout_vld, nentries_dout, err_mismatch, err_addr
    );

    modport slave (
        input  ena, wea, writeaddr, din, nent_we, nent_din, page_clr,
        input  enb, readaddr,
        output dout, dout_vld, nentries_dout, err_mismatch, err_addr
    );

endinterface

// File: rtl/tf_mem_page_ctr.sv
// Per-page entry-count register, write counter and sticky count-mismatch flag.
module tf_mem_page_ctr
    import tf_mem_paged_bram_pkg::*;
#(
    parameter int NENT_WIDTH = NENT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  nent_we,
    input  logic [NENT_WIDTH-1:0] nent_din,
    input  logic                  clr,
    output logic [NENT_WIDTH-1:0] nentries,
    output logic                  err
);

    localparam logic [NENT_WIDTH-1:0] CNT_MAX = '1;

    logic [NENT_WIDTH-1:0] wr_count;
    logic [NENT_WIDTH-1:0] eff_count;

    // Count including a write landing this cycle, held at the top value
    always_comb begin
        eff_count = wr_count;
        if (wr && wr_count != CNT_MAX) eff_count = wr_count + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
            nentries <= '0;
            err      <= 1'b0;
        end else if (clr) begin
            wr_count <= '0;
            nentries <= '0;
        end else begin
            wr_count <= eff_count;
            if (nent_we) begin
                nentries <= nent_din;
                if (nent_din != eff_count) err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tf_mem_paged_bram.sv
// Paged simple-dual-port BRAM with read pipeline, per-page counts and address checks.
module tf_mem_paged_bram
    import tf_mem_paged_bram_pkg::*;
#(
    parameter int RAM_WIDTH    = VMPROJ_WIDTH,
    parameter int NUM_PAGES    = 2,
    parameter int PAGE_DEPTH   = 128,
    parameter int NENT_WIDTH   = NENT_WIDTH_DEF,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    tf_mem_paged_bram_if.slave  bus
);

    localparam int DEPTH  = NUM_PAGES * PAGE_DEPTH;
    localparam int RAM_AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [RAM_WIDTH-1:0] ram [DEPTH];

    logic [31:0]          wpage;
    logic [31:0]          rpage;
    logic                 wr_hit;
    logic                 wr_go;
    logic                 rd_ok;
    logic [RAM_AW-1:0]    waddr;
    logic [RAM_AW-1:0]    raddr;
    logic [RAM_WIDTH-1:0] d1;
    logic                 v1;

    assign wpage  = page_of(32'(bus.writeaddr), PAGE_DEPTH);
    assign rpage  = page_of(32'(bus.readaddr), PAGE_DEPTH);
    assign wr_hit = bus.ena & bus.wea;
    assign wr_go  = wr_hit & (wpage < 32'(NUM_PAGES));
    assign rd_ok  = rpage < 32'(NUM_PAGES);
    assign waddr  = bus.writeaddr[RAM_AW-1:0];
    assign raddr  = bus.readaddr[RAM_AW-1:0];

    always_ff @(posedge clk) begin
        if (wr_go) ram[waddr] <= bus.din;
    end

    // First read stage samples the array before this edge's write (read-first)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= bus.enb;
            if (bus.enb) d1 <= rd_ok ? ram[raddr] : '0;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [RAM_WIDTH-1:0] d2;
            logic                 v2;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    d2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) d2 <= d1;
                end
            end

            assign bus.dout     = d2;
            assign bus.dout_vld = v2;
        end else begin : g_lat1
            assign bus.dout     = d1;
            assign bus.dout_vld = v1;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.err_addr <= 1'b0;
        end else if ((wr_hit & ~wr_go) | (bus.enb & ~rd_ok)) begin
            bus.err_addr <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PAGES; p++) begin : g_page
        tf_mem_page_ctr #(
            .NENT_WIDTH (NENT_WIDTH)
        ) u_ctr (
            .clk      (clk),
            .reset    (reset),
            .wr       (wr_go && wpage == 32'(p)),
            .nent_we  (bus.nent_we[p]),
            .nent_din (bus.nent_din[p*NENT_WIDTH +: NENT_WIDTH]),
            .clr      (bus.page_clr[p]),
            .nentries (bus.nentries_dout[p*NENT_WIDTH +: NENT_WIDTH]),
            .err      (bus.err_mismatch[p])
        );
    end

endmodule

// File: tb/tb_tf_mem_paged_bram.sv
// Scoreboard bench for tf_mem_paged_bram: three pages of 64 words, two-cycle read latency.
module tb_tf_mem_paged_bram;

    localparam int RW = 21;
    localparam int NP = 3;
    localparam int PD = 64;
    localparam int NW = 8;
    localparam int AW = 8;
    localparam int RL = 2;
    localparam int VALID_WORDS = NP * PD;

    typedef struct {
        logic [RW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [RW-1:0] mem [256];
    int            cnt [NP];
    int            nent [NP];
    bit            errm [NP];
    bit            erra;
    exp_t          sbq [$];

    tf_mem_paged_bram_if #(
        .RAM_WIDTH (RW), .NUM_PAGES (NP), .NENT_WIDTH (NW), .ADDR_WIDTH (AW)
    ) bus ();

    tf_mem_paged_bram #(
        .RAM_WIDTH (RW), .NUM_PAGES (NP), .PAGE_DEPTH (PD),
        .NENT_WIDTH (NW), .ADDR_WIDTH (AW), .READ_LATENCY (RL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.ena = 1'b0;
        bus.wea = 1'b0;
        bus.writeaddr = '0;
        bus.din = '0;
        bus.nent_we = '0;
        bus.nent_din = '0;
        bus.page_clr = '0;
        bus.enb = 1'b0;
        bus.readaddr = '0;
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            cnt[p] = 0;
            nent[p] = 0;
            errm[p] = 1'b0;
        end
        erra = 1'b0;
    endtask

    // Apply current inputs for one clock and advance the reference model
    task automatic step();
        int   wp;
        int   rp;
        bit   wr;
        int   nxt;
        int   nd;
        int   cnt_n [NP];
        int   nent_n [NP];
        bit   errm_n [NP];
        bit   erra_n;
        exp_t e;
        wp = int'(bus.writeaddr) / PD;
        rp = int'(bus.readaddr) / PD;
        wr = bus.ena && bus.wea;
        erra_n = erra;
        if (bus.enb) begin
            e.data = (rp < NP) ? mem[bus.readaddr] : '0;
            e.due = cyc + RL;
            sbq.push_back(e);
            if (rp >= NP) erra_n = 1'b1;
        end
        for (int p = 0; p < NP; p++) begin
            cnt_n[p] = cnt[p];
            nent_n[p] = nent[p];
            errm_n[p] = errm[p];
            nxt = cnt[p];
            if (wr && wp == p) nxt = (cnt[p] < 255) ? cnt[p] + 1 : 255;
            if (bus.page_clr[p]) begin
                cnt_n[p] = 0;
                nent_n[p] = 0;
            end else begin
                cnt_n[p] = nxt;
                if (bus.nent_we[p]) begin
                    nd = int'(bus.nent_din[p*NW +: NW]);
                    nent_n[p] = nd;
                    if (nd != nxt) errm_n[p] = 1'b1;
                end
            end
        end
        if (wr) begin
            if (wp < NP) mem[bus.writeaddr] = bus.din;
            else erra_n = 1'b1;
        end
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            cnt[p] = cnt_n[p];
            nent[p] = nent_n[p];
            errm[p] = errm_n[p];
        end
        erra = erra_n;
        #1;
    endtask

    task automatic wr_word(input int a, input logic [RW-1:0] d);
        idle();
        bus.ena = 1'b1;
        bus.wea = 1'b1;
        bus.writeaddr = AW'(a);
        bus.din = d;
        step();
    endtask

    task automatic rd_word(input int a);
        idle();
        bus.enb = 1'b1;
        bus.readaddr = AW'(a);
        step();
    endtask

    // Monitor: pops the scoreboard whenever a read result is due
    always @(negedge clk) begin
        logic [NP*NW-1:0] en;
        logic [NP-1:0]    em;
        for (int p = 0; p < NP; p++) begin
            en[p*NW +: NW] = NW'(nent[p]);
            em[p] = errm[p];
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            check("dout_vld", 64'(bus.dout_vld), 64'(1));
            check("dout", 64'(bus.dout), 64'(sbq[0].data));
            void'(sbq.pop_front());
        end else begin
            check("dout_vld_idle", 64'(bus.dout_vld), 64'(0));
        end
        check("nentries_dout", 64'(bus.nentries_dout), 64'(en));
        check("err_mismatch", 64'(bus.err_mismatch), 64'(em));
        check("err_addr", 64'(bus.err_addr), 64'(erra));
    end

    initial begin
        idle();
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state held through idle cycles
        repeat (10) step();
        check("rst_dout", 64'(bus.dout), 64'(0));
        check("rst_nent", 64'(bus.nentries_dout), 64'(0));

        // Fill every valid word, confirm full-page counts, then start fresh pages
        for (int a = 0; a < VALID_WORDS; a++) wr_word(a, RW'($urandom));
        idle();
        bus.nent_we = '1;
        for (int p = 0; p < NP; p++) bus.nent_din[p*NW +: NW] = NW'(PD);
        step();
        check("full_cnt_err", 64'(bus.err_mismatch), 64'(0));
        idle();
        bus.page_clr = '1;
        step();

        // Five words on page 1, matching count, read back offset 2
        for (int i = 0; i < 5; i++) wr_word(PD + i, RW'(i + 1));
        idle();
        bus.nent_we = 3'b010;
        bus.nent_din[NW +: NW] = 8'd5;
        step();
        check("t2_nent1", 64'(bus.nentries_dout[NW +: NW]), 64'(5));
        check("t2_err", 64'(bus.err_mismatch), 64'(0));
        rd_word(PD + 2);
        idle();
        step();
        check("t2_dout", 64'(bus.dout), 64'(3));

        // Same-address read and write: old word comes back first
        wr_word(7, RW'('hAA));
        idle();
        bus.ena = 1'b1;
        bus.wea = 1'b1;
        bus.writeaddr = 8'd7;
        bus.din = RW'('h55);
        bus.enb = 1'b1;
        bus.readaddr = 8'd7;
        step();
        idle();
        step();
        check("t3_old", 64'(bus.dout), 64'('hAA));
        rd_word(7);
        idle();
        step();
        check("t3_new", 64'(bus.dout), 64'('h55));

        // Three writes but a count of four: sticky mismatch on page 0
        idle();
        bus.page_clr = 3'b001;
        step();
        for (int i = 0; i < 3; i++) wr_word(i, RW'(i + 'h100));
        idle();
        bus.nent_we = 3'b001;
        bus.nent_din[NW-1:0] = 8'd4;
        step();
        check("t4_err", 64'(bus.err_mismatch[0]), 64'(1));
        idle();
        bus.page_clr = 3'b001;
        step();
        check("t4_sticky", 64'(bus.err_mismatch[0]), 64'(1));
        check("t4_nent0", 64'(bus.nentries_dout[NW-1:0]), 64'(0));

        // Clear beats load; out-of-range page write and read
        idle();
        bus.page_clr = 3'b100;
        bus.nent_we = 3'b100;
        bus.nent_din[2*NW +: NW] = 8'd9;
        step();
        check("t5_nent2", 64'(bus.nentries_dout[2*NW +: NW]), 64'(0));
        check("t5_err2", 64'(bus.err_mismatch[2]), 64'(0));
        check("t5_erra0", 64'(bus.err_addr), 64'(0));
        wr_word(NP * PD, RW'('h1234));
        check("t5_erra", 64'(bus.err_addr), 64'(1));
        rd_word(NP * PD);
        rd_word(0);
        idle();
        step();
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            bus.ena = 1'($urandom_range(0, 1));
            bus.wea = ($urandom_range(0, 3) != 0);
            bus.writeaddr = ($urandom_range(0, 15) == 0) ?
                AW'($urandom_range(VALID_WORDS, 255)) : AW'($urandom_range(0, VALID_WORDS - 1));
            bus.din = RW'($urandom);
            bus.enb = 1'($urandom_range(0, 1));
            bus.readaddr = ($urandom_range(0, 15) == 0) ?
                AW'($urandom_range(VALID_WORDS, 255)) : AW'($urandom_range(0, VALID_WORDS - 1));
            for (int p = 0; p < NP; p++) begin
                bus.page_clr[p] = ($urandom_range(0, 31) == 0);
                bus.nent_we[p] = ($urandom_range(0, 7) == 0);
                case ($urandom_range(0, 2))
                    0: bus.nent_din[p*NW +: NW] = NW'(cnt[p]);
                    1: bus.nent_din[p*NW +: NW] = NW'(cnt[p] + 1);
                    default: bus.nent_din[p*NW +: NW] = NW'($urandom);
                endcase
            end
            step();
        end
        idle();
        repeat (3) step();

        // Reset one cycle after a read: the result never appears
        rd_word(5);
        reset = 1'b1;
        sbq.delete();
        model_clear();
        idle();
        repeat (3) step();
        check("t6_dout_rst", 64'(bus.dout), 64'(0));
        reset = 1'b0;
        repeat (4) step();
        check("t6_dout", 64'(bus.dout), 64'(0));
        check("t6_erra", 64'(bus.err_addr), 64'(0));
        check("t6_errm", 64'(bus.err_mismatch), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
